// File: rtl/cobs_serial_rx.sv
// cobs_serial_rx: 8N1 UART receiver feeding a COBS decoder with a one-entry output slot.
// Define COBS_RX_MAJORITY_EN to vote 3 samples around mid-bit instead of a single sample.
module cobs_serial_rx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       busy,
    output logic       raw_valid,
    output logic [7:0] raw_data,
    output logic       frame_sync,
    output logic       o_flag,
    output logic [7:0] o_data,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        r_state;
    logic [1:0]    r_sync;
    logic [1:0]    r_win;
    logic [CW-1:0] r_clk;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_cnt;
    logic          r_zpend;
    logic          r_hold_valid;
    logic [7:0]    r_hold_data;
    logic          w_rx;
    logic          w_bit;
    logic          w_zero;
    logic          w_code;
    logic          w_emit;
    logic [7:0]    w_emit_data;

    assign w_rx = r_sync[1];
    // Decisions land one cycle after mid-bit so both builds share identical strobe timing.
`ifdef COBS_RX_MAJORITY_EN
    assign w_bit = (r_win[1] & r_win[0]) | (r_win[1] & w_rx) | (r_win[0] & w_rx);
`else
    assign w_bit = r_win[0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_win     <= 2'b11;
            r_state   <= IDLE;
            r_clk     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            raw_valid <= 1'b0;
            raw_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rxd};
            r_win     <= {r_win[0], w_rx};
            raw_valid <= 1'b0;
            frame_err <= 1'b0;
            r_clk     <= r_clk + 1'b1;
            case (r_state)
                IDLE: begin
                    r_clk <= '0;
                    if (r_win[0] && !w_rx) r_state <= START;
                end
                START: if (r_clk == HALF) begin
                    r_clk   <= '0;
                    r_state <= w_bit ? IDLE : DATA;
                end
                DATA: if (r_clk == LAST) begin
                    r_clk   <= '0;
                    r_shift <= {w_bit, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= STOP;
                end
                STOP: if (r_clk == LAST) begin
                    r_clk     <= '0;
                    raw_valid <= w_bit;
                    frame_err <= !w_bit;
                    if (w_bit) raw_data <= r_shift;
                    r_state   <= w_bit ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: if (w_rx) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_zero      = raw_data == 8'h00;
    assign w_code      = r_cnt == 8'h00;
    assign w_emit      = raw_valid && !w_zero && (!w_code || r_zpend);
    assign w_emit_data = w_code ? 8'h00 : raw_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_zpend      <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            frame_sync   <= 1'b0;
            overrun      <= 1'b0;
            o_flag       <= 1'b0;
            o_data       <= '0;
        end else begin
            frame_sync <= raw_valid && w_zero;
            overrun    <= w_emit && r_hold_valid;
            o_flag     <= r_hold_valid && !busy;
            if (r_hold_valid && !busy) begin
                o_data       <= r_hold_data;
                r_hold_valid <= 1'b0;
            end
            if (w_emit && !r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= w_emit_data;
            end
            if (raw_valid) begin
                r_cnt   <= w_zero ? 8'h00 : (w_code ? raw_data - 8'h01 : r_cnt - 8'h01);
                r_zpend <= w_zero ? 1'b0 : (w_code ? raw_data != 8'hFF : r_zpend);
            end
        end
    end
endmodule

// File: tb/tb_cobs_serial_rx.sv
// tb_cobs_serial_rx: directed COBS frames over a serial line, scoreboarded decoded and raw bytes.
module tb_cobs_serial_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       busy = 1'b0;
    logic       raw_valid, frame_sync, o_flag, frame_err, overrun;
    logic [7:0] raw_data, o_data;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] raw_q[$];
    int n_raw = 0, n_sync = 0, n_ferr = 0, n_ovr = 0, n_flag = 0;
    int cyc = 0, last_raw = 0;
    bit chk_lat = 1'b1;
    logic prev_flag = 1'b0;
    int s_raw, s_sync, s_ferr, s_ovr, s_flag;

    always #5 clk = ~clk;

    cobs_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .busy(busy),
        .raw_valid(raw_valid), .raw_data(raw_data), .frame_sync(frame_sync),
        .o_flag(o_flag), .o_data(o_data), .frame_err(frame_err), .overrun(overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (raw_valid) begin
                n_raw++;
                last_raw = cyc;
                if (raw_q.size() == 0) check("raw_unexpected", raw_data, 256);
                else check("raw_data", raw_data, raw_q.pop_front());
            end
            if (o_flag) begin
                n_flag++;
                check("o_flag_back_to_back", prev_flag, 0);
                if (chk_lat) check("o_flag_latency", cyc - last_raw, 2);
                if (exp_q.size() == 0) check("o_data_unexpected", o_data, 256);
                else check("o_data", o_data, exp_q.pop_front());
            end
            n_sync += frame_sync;
            n_ferr += frame_err;
            n_ovr  += overrun;
        end
        prev_flag = o_flag;
    end

    task automatic send(input logic [7:0] b, input logic stop = 1'b1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!stop) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic tx(input logic [7:0] b);
        raw_q.push_back(b);
        send(b);
    endtask

    task automatic snap();
        s_raw = n_raw; s_sync = n_sync; s_ferr = n_ferr; s_ovr = n_ovr; s_flag = n_flag;
    endtask

    task automatic settle();
        repeat (4 * CPB) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_outputs", {raw_valid, raw_data, frame_sync, o_flag, o_data, frame_err, overrun}, 0);
        rst = 1'b1;
        repeat (3 * CPB) @(negedge clk);

        // single data byte inside a block with cnt=2
        snap();
        exp_q.push_back(8'h41);
        tx(8'h00); tx(8'h03); tx(8'h41);
        settle();
        check("p1_pending", exp_q.size(), 0);
        check("p1_flags", n_flag - s_flag, 1);
        check("p1_raw", n_raw - s_raw, 3);

        snap();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h00); exp_q.push_back(8'h33);
        tx(8'h00); tx(8'h03); tx(8'h11); tx(8'h22); tx(8'h02); tx(8'h33); tx(8'h00);
        settle();
        check("p2_pending", exp_q.size(), 0);
        check("p2_flags", n_flag - s_flag, 4);
        check("p2_sync", n_sync - s_sync, 2);

        // full 0xFF block: no implicit zero after it
        snap();
        for (int i = 1; i <= 254; i++) exp_q.push_back(8'(i));
        tx(8'h00); tx(8'hFF);
        for (int i = 1; i <= 254; i++) tx(8'(i));
        tx(8'h01); tx(8'h00);
        settle();
        check("p3_pending", exp_q.size(), 0);
        check("p3_flags", n_flag - s_flag, 254);
        check("p3_sync", n_sync - s_sync, 2);

        snap();
        exp_q.push_back(8'h77);
        tx(8'h00);
        send(8'h03, 1'b0);
        tx(8'h02); tx(8'h77); tx(8'h00);
        settle();
        check("p4_ferr", n_ferr - s_ferr, 1);
        check("p4_raw", n_raw - s_raw, 4);
        check("p4_flags", n_flag - s_flag, 1);
        check("p4_pending", exp_q.size(), 0);

        snap();
        chk_lat = 1'b0;
        busy = 1'b1;
        exp_q.push_back(8'hAA);
        tx(8'h00); tx(8'h03); tx(8'hAA); tx(8'hBB);
        settle();
        check("p5_overrun", n_ovr - s_ovr, 1);
        check("p5_held_flags", n_flag - s_flag, 0);
        check("p5_held_pending", exp_q.size(), 1);
        busy = 1'b0;
        repeat (10) @(negedge clk);
        check("p5_flags", n_flag - s_flag, 1);
        check("p5_pending", exp_q.size(), 0);
        check("p5_o_data", o_data, 8'hAA);
        tx(8'h00);
        settle();

        // reset mid-byte with a byte sitting in the holding slot
        busy = 1'b1;
        tx(8'h00); tx(8'h05); tx(8'h11);
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        busy = 1'b0;
        repeat (4) @(negedge clk);
        check("p6_reset_outputs", {raw_valid, raw_data, frame_sync, o_flag, o_data, frame_err, overrun}, 0);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk_lat = 1'b1;
        snap();
        exp_q.push_back(8'h55);
        tx(8'h00); tx(8'h02); tx(8'h55); tx(8'h00);
        settle();
        check("p6_pending", exp_q.size(), 0);
        check("p6_flags", n_flag - s_flag, 1);
        check("p6_sync", n_sync - s_sync, 2);
        check("raw_pending", raw_q.size(), 0);
        check("overrun_total", n_ovr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cobs_serial_rx.md
# cobs_serial_rx

UART receiver with an integrated COBS frame decoder. It turns an asynchronous 8N1 serial line into a stream of decoded payload bytes, with a one-cycle strobe per byte, consumer backpressure, and frame-delimiter indication. It sits between the board's RX pin and the command/state machine that writes frame-buffer and palette RAM.

## Interface
Parameters:
- CLKS_PER_BIT, 234: clk cycles per serial bit (27 MHz / 115200); minimum 8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- rxd  in  1  asynchronous serial input; idle high
- busy  in  1  consumer backpressure; while high, no new o_flag is issued
- raw_valid  out  1  one-cycle strobe: raw UART byte received with a valid stop bit
- raw_data  out  8  last raw UART byte; stable until the next raw_valid
- frame_sync  out  1  one-cycle strobe: raw 0x00 delimiter received
- o_flag  out  1  one-cycle strobe: decoded byte available on o_data
- o_data  out  8  decoded byte; stable until the next o_flag
- frame_err  out  1  one-cycle strobe: stop bit sampled low
- overrun  out  1  one-cycle strobe: decoded byte dropped because the holding slot was full

## Operation
- rxd passes through a 2-flop synchronizer, which resets to 1.
- UART states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE -> START on a synchronized falling edge.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles.
  - STOP: sample one bit period later.
    - High: pulse raw_valid and update raw_data, then go to IDLE.
    - Low: pulse frame_err and discard the byte, then go to WAIT_HIGH.
  - WAIT_HIGH -> IDLE once the line reads high.
- COBS decoder state: cnt (8 bit, remaining data bytes in the block), zpend (implicit zero owed).
- On each raw_valid:
  - Byte 0x00: pulse frame_sync. Set cnt=0 and zpend=0. Nothing is emitted. The trailing implicit zero of a frame is therefore suppressed.
  - Else if cnt==0 (code byte c): if zpend, emit 0x00. Then set cnt=c-1 and zpend=(c!=0xFF).
  - Else (data byte): emit the byte and decrement cnt.
- Emit path: a one-entry holding slot (hold_valid, hold_data).
  - An emitted byte goes to the slot if it is empty.
  - If the slot is full, the new byte is dropped and overrun is pulsed.
  - When hold_valid=1 and busy=0, pulse o_flag, drive o_data=hold_data, and clear the slot.
- A 0x00 delimiter does not flush an already-held byte; that byte is still delivered.
- Reset, including mid-byte or mid-frame: UART returns to IDLE; cnt=0, zpend=0, slot empty; all outputs 0.

## Timing
- raw_valid occurs on the cycle after the stop-bit sample.
- The decoder updates cnt/zpend and writes the slot on the same edge that raw_valid is seen. So o_flag is high exactly 2 cycles after raw_valid when busy is low.
- busy high holds o_flag low. o_flag fires on the first cycle busy is sampled low.
- o_flag never stays high for 2 consecutive cycles.
- Emission happens at most once per raw byte, so no overrun is possible when the consumer deasserts busy within 8*CLKS_PER_BIT cycles.
- frame_sync and o_flag are never asserted for the same raw byte.

## Configuration
- COBS_RX_MAJORITY_EN:
  - Defined: each start, data and stop sample is the majority of 3 synchronized samples taken at mid-bit-1, mid-bit and mid-bit+1.
  - Undefined: a single sample at mid-bit.
- Strobe timing is identical in both builds.

## Test plan
- Serial 0x41 at CLKS_PER_BIT=16, busy=0, mid-frame with cnt=2 -> raw_valid with raw_data=0x41, then one o_flag with o_data=0x41.
- Frame 00 03 11 22 02 33 00 -> o_flag sequence 0x11, 0x22, 0x00, 0x33; frame_sync pulses twice; no trailing zero.
- Frame 00 FF followed by 254 bytes, then 01 00 -> 254 bytes out; no implicit zero after the FF block; frame_sync at the end.
- Byte sent with the stop bit low -> frame_err pulse, no raw_valid, no o_flag; the next valid byte is received normally.
- busy held high across two emitted bytes -> first byte held, overrun pulses on the second; after busy falls, a single o_flag carries the first byte.
- rst low mid-byte, then the frame 00 02 55 00 -> clean output of 0x55 only.
